// File: rtl/alu_muldiv_pipe.sv
// Execute-stage ALU with registered results, single-cycle logic/shift/compare ops
// and multi-cycle unsigned shift-add multiply and restoring divide.
module alu_muldiv_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_hi,
    output logic             zero,
    output logic             div_by_zero
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = SHAMT_W + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MULU = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    // Handshake: an operation is taken on a rising edge where in_valid && in_ready;
    // upstream keeps its inputs stable while in_ready is low.
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   alu_hi_q, alu_hi_d;
    logic               out_valid_q, out_valid_d;
    logic               dbz_q, dbz_d;

    logic               accept;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sc_result;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_shift;
    logic [WIDTH-1:0]   mul_lo_nx;
    logic [WIDTH-1:0]   mul_hi_nx;

    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_nx;
    logic [WIDTH-1:0]   div_quo_nx;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign shamt    = operand_b[SHAMT_W-1:0];

    always_comb begin
        sc_result = '0;
        case (alu_op)
            OP_ADD:  sc_result = operand_a + operand_b;
            OP_SUB:  sc_result = operand_a - operand_b;
            OP_AND:  sc_result = operand_a & operand_b;
            OP_OR:   sc_result = operand_a | operand_b;
            OP_XOR:  sc_result = operand_a ^ operand_b;
            OP_NOR:  sc_result = ~(operand_a | operand_b);
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
            OP_SLL:  sc_result = operand_a << shamt;
            OP_SRL:  sc_result = operand_a >> shamt;
            OP_SRA:  sc_result = unsigned'($signed(operand_a) >>> shamt);
            default: sc_result = '0;
        endcase
    end

    // Multiply step: {hi,lo} holds the running product with the unused multiplier
    // bits in lo; add multiplicand into hi when lo[0] is set, then shift right.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        mul_shift = {mul_sum, lo_q};
        mul_lo_nx = mul_shift[WIDTH:1];
        mul_hi_nx = mul_shift[2*WIDTH:WIDTH+1];
    end

    // Divide step: hi is the partial remainder, lo shifts dividend bits out and
    // quotient bits in.
    always_comb begin
        div_trial  = {hi_q, lo_q[WIDTH-1]};
        div_diff   = div_trial - {1'b0, b_q};
        div_ge     = (div_trial >= {1'b0, b_q});
        div_rem_nx = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
        div_quo_nx = {lo_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        result_d    = result_q;
        alu_hi_d    = alu_hi_q;
        out_valid_d = 1'b0;
        dbz_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (alu_op == OP_MULU) begin
                        state_d = ST_MUL;
                        cnt_d   = CNT_W'(WIDTH);
                        a_d     = operand_a;
                        b_d     = operand_b;
                        lo_d    = operand_b;
                        hi_d    = '0;
                    end else if (alu_op == OP_DIVU) begin
                        state_d = ST_DIV;
                        cnt_d   = CNT_W'(WIDTH);
                        a_d     = operand_a;
                        b_d     = operand_b;
                        lo_d    = operand_a;
                        hi_d    = '0;
                    end else begin
                        result_d    = sc_result;
                        alu_hi_d    = '0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                lo_d  = mul_lo_nx;
                hi_d  = mul_hi_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_IDLE;
                    result_d    = mul_lo_nx;
                    alu_hi_d    = mul_hi_nx;
                    out_valid_d = 1'b1;
                end
            end
            ST_DIV: begin
                lo_d  = div_quo_nx;
                hi_d  = div_rem_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    // Divide by zero reports all-ones quotient and the dividend as remainder.
                    if (b_q == '0) begin
                        result_d = '1;
                        alu_hi_d = a_q;
                        dbz_d    = 1'b1;
                    end else begin
                        result_d = div_quo_nx;
                        alu_hi_d = div_rem_nx;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            result_q    <= '0;
            alu_hi_q    <= '0;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            result_q    <= result_d;
            alu_hi_q    <= alu_hi_d;
            out_valid_q <= out_valid_d;
            dbz_q       <= dbz_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_result  = result_q;
    assign alu_hi      = alu_hi_q;
    assign zero        = (result_q == '0);
    assign div_by_zero = dbz_q;

endmodule
